// File: rtl/fsm_vector_sequencer.sv
// Vector sequencer for small benchmark FSMs: holds the FSM in reset, replays stored stimulus,
// compares outputs against expected words and reports mismatches. Optional SEQ_CAPTURE_EN adds a y_in capture RAM.
module fsm_vector_sequencer #(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int XW    = 10,
  parameter int YW    = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [XW-1:0] cfg_stim,
  input  logic [YW-1:0] cfg_exp,
  input  logic [AW:0]   cfg_len,
  input  logic          start,
  input  logic          abort,
  output logic          dut_rst,
  output logic [XW-1:0] x_out,
  input  logic [YW-1:0] y_in,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW:0]   fail_cnt,
  output logic [AW-1:0] first_fail,
  input  logic [AW-1:0] rd_addr,
  output logic [YW-1:0] rd_data
);

  typedef enum logic [1:0] {S_IDLE, S_RST, S_RUN, S_DONE} state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [XW-1:0] stim_mem [DEPTH];
  logic [YW-1:0] exp_mem  [DEPTH];

  state_t        state_q, state_d;
  logic [AW:0]   len_q, len_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          dut_rst_q, dut_rst_d;
  logic [XW-1:0] x_out_q, x_out_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [AW:0]   fail_cnt_q, fail_cnt_d;
  logic [AW-1:0] first_fail_q, first_fail_d;

  logic mismatch;
  logic last_vec;
  logic cmp_en;

  assign mismatch = (y_in != exp_mem[idx_q]);
  assign last_vec = ({1'b0, idx_q} == (len_q - 1'b1));
  assign cmp_en   = (state_q == S_RUN) && !abort;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    idx_d        = idx_q;
    dut_rst_d    = dut_rst_q;
    x_out_d      = x_out_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    fail_cnt_d   = fail_cnt_q;
    first_fail_d = first_fail_q;
    case (state_q)
      S_IDLE: begin
        dut_rst_d = 1'b1;
        if (start) begin
          len_d   = (cfg_len > DEPTH_L) ? DEPTH_L : cfg_len;
          state_d = S_RST;
        end
      end
      S_RST: begin
        if (abort) begin
          state_d   = S_IDLE;
          dut_rst_d = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b0;
          pass_d    = 1'b0;
        end else begin
          busy_d       = 1'b1;
          fail_cnt_d   = '0;
          first_fail_d = '0;
          idx_d        = '0;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          dut_rst_d    = 1'b0;
          x_out_d      = stim_mem[0];
          // An empty run skips RUN; DONE then raises done one edge later.
          state_d      = (len_q == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d   = S_IDLE;
          dut_rst_d = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b0;
          pass_d    = 1'b0;
        end else begin
          if (mismatch) begin
            fail_cnt_d = fail_cnt_q + 1'b1;
            if (fail_cnt_q == '0) first_fail_d = idx_q;
          end
          if (last_vec) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (fail_cnt_d == '0);
          end else begin
            idx_d   = idx_q + 1'b1;
            x_out_d = stim_mem[idx_q + 1'b1];
          end
        end
      end
      S_DONE: begin
        busy_d = 1'b0;
        done_d = 1'b1;
        pass_d = (fail_cnt_q == '0);
        if (start) begin
          len_d     = (cfg_len > DEPTH_L) ? DEPTH_L : cfg_len;
          dut_rst_d = 1'b1;
          state_d   = S_RST;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      idx_q        <= '0;
      dut_rst_q    <= 1'b1;
      x_out_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_cnt_q   <= '0;
      first_fail_q <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      dut_rst_q    <= dut_rst_d;
      x_out_q      <= x_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_cnt_q   <= fail_cnt_d;
      first_fail_q <= first_fail_d;
    end
  end

  // Vector RAM is not reset; the host reloads it as needed.
  always_ff @(posedge clk) begin
    if (cfg_we && !busy_q) begin
      stim_mem[cfg_addr] <= cfg_stim;
      exp_mem[cfg_addr]  <= cfg_exp;
    end
  end

  assign dut_rst    = dut_rst_q;
  assign x_out      = x_out_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_cnt   = fail_cnt_q;
  assign first_fail = first_fail_q;

`ifdef SEQ_CAPTURE_EN
  logic [YW-1:0] cap_mem [DEPTH];
  logic [YW-1:0] rd_data_q, rd_data_d;

  always_ff @(posedge clk) begin
    if (cmp_en) cap_mem[idx_q] <= y_in;
  end

  always_comb begin
    rd_data_d = cap_mem[rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
`else
  logic unused_rd;
  assign unused_rd = ^{rd_addr, cmp_en};
  assign rd_data   = '0;
`endif

endmodule

// File: tb/tb_fsm_vector_sequencer.sv
// Scoreboard bench for fsm_vector_sequencer driving a small negedge Mealy stand-in FSM;
// run outcomes are predicted by a behavioural replay of the stored vectors.
module tb_fsm_vector_sequencer;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int XW    = 10;
  localparam int YW    = 13;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [XW-1:0] cfg_stim = '0;
  logic [YW-1:0] cfg_exp = '0;
  logic [AW:0]   cfg_len = '0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          dut_rst;
  logic [XW-1:0] x_out;
  logic [YW-1:0] y_in;
  logic          busy, done, pass;
  logic [AW:0]   fail_cnt;
  logic [AW-1:0] first_fail;
  logic [AW-1:0] rd_addr = '0;
  logic [YW-1:0] rd_data;

  always #5 clk = ~clk;

  fsm_vector_sequencer #(.DEPTH(DEPTH), .AW(AW), .XW(XW), .YW(YW)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_stim(cfg_stim),
    .cfg_exp(cfg_exp), .cfg_len(cfg_len), .start(start), .abort(abort),
    .dut_rst(dut_rst), .x_out(x_out), .y_in(y_in), .busy(busy), .done(done),
    .pass(pass), .fail_cnt(fail_cnt), .first_fail(first_fail),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  function automatic logic [3:0] upd(input logic [3:0] s, input logic [XW-1:0] x);
    return {s[2:0], s[3]} ^ x[3:0] ^ x[9:6];
  endfunction

  function automatic logic [YW-1:0] outf(input logic [3:0] s, input logic [XW-1:0] x);
    return {s, x[8:0]} ^ {3'b000, x};
  endfunction

  // Stand-in benchmark: async reset, steps on the falling edge, Mealy output.
  logic [3:0] bs;
  always @(negedge clk or posedge dut_rst) begin
    if (dut_rst) bs <= 4'd0;
    else         bs <= upd(bs, x_out);
  end
  assign y_in = outf(bs, x_out);

  typedef struct { int fc; int ff; bit ps; } exp_t;
  exp_t sb_q[$];

  logic [XW-1:0] stim_m [DEPTH];
  logic [YW-1:0] exp_m  [DEPTH];
  logic [YW-1:0] cap_m  [DEPTH];

  int n_chk = 0;
  int n_ok  = 0;

  task automatic chk(input string name, input longint act, input longint req);
    n_chk++;
    if (act == req) n_ok++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
  endtask

  // Replays the first L vectors through the benchmark's rules and counts mismatches.
  function automatic void model(input int cl, output int fc, output int ff, output bit ps);
    int L;
    logic [3:0] s;
    logic [YW-1:0] y;
    L = (cl > DEPTH) ? DEPTH : cl;
    s = 4'd0; fc = 0; ff = 0;
    for (int k = 0; k < L; k++) begin
      s = upd(s, stim_m[k]);
      y = outf(s, stim_m[k]);
      cap_m[k] = y;
      if (y != exp_m[k]) begin
        if (fc == 0) ff = k;
        fc++;
      end
    end
    ps = (fc == 0);
  endfunction

  task automatic wr(input int a, input logic [XW-1:0] s, input logic [YW-1:0] e);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_stim = s; cfg_exp = e;
    stim_m[a] = s; exp_m[a] = e;
  endtask

  task automatic wr_end();
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic new_vectors(input int corrupt_pct);
    logic [XW-1:0] s_arr [DEPTH];
    logic [YW-1:0] e_arr [DEPTH];
    logic [3:0] s;
    logic [YW-1:0] flip;
    s = 4'd0;
    for (int k = 0; k < DEPTH; k++) begin
      s_arr[k] = XW'($urandom);
      s = upd(s, s_arr[k]);
      e_arr[k] = outf(s, s_arr[k]);
      if ($urandom_range(99, 0) < corrupt_pct) begin
        flip = YW'($urandom_range(8191, 1));
        e_arr[k] = e_arr[k] ^ flip;
      end
    end
    for (int k = 0; k < DEPTH; k++) wr(k, s_arr[k], e_arr[k]);
    wr_end();
  endtask

  task automatic run_seq(input int cl);
    int L, fc, ff;
    bit ps;
    exp_t e;
    L = (cl > DEPTH) ? DEPTH : cl;
    model(cl, fc, ff, ps);
    e.fc = fc; e.ff = ff; e.ps = ps;
    @(negedge clk);
    cfg_len = (AW+1)'(cl);
    start = 1'b1;
    sb_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    chk("p0_busy", busy, 0);
    chk("p0_dut_rst", dut_rst, 1);
    @(posedge clk); #1;
    chk("p1_busy", busy, 1);
    chk("p1_dut_rst", dut_rst, 0);
    chk("p1_done", done, 0);
    if (L > 0) chk("p1_x_out", x_out, stim_m[0]);
    for (int k = 1; k < L; k++) begin
      @(posedge clk); #1;
      chk("run_x_out", x_out, stim_m[k]);
      chk("run_busy", busy, 1);
      chk("run_done", done, 0);
    end
    @(posedge clk); #1;
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_pass", pass, ps);
    chk("end_dut_rst", dut_rst, 0);
    if (L > 0) chk("end_x_out_hold", x_out, stim_m[L-1]);
  endtask

  // Monitor: pops one expectation per rising done and compares the run result.
  initial begin
    bit done_d;
    exp_t e;
    done_d = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !done_d) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("sb_fail_cnt", fail_cnt, e.fc);
          chk("sb_pass", pass, e.ps);
          if (e.fc != 0) chk("sb_first_fail", first_fail, e.ff);
        end
      end
      done_d = done;
    end
  end

  initial begin
    #2 rst = 1'b1;
    #1;
    chk("rst_dut_rst", dut_rst, 1);
    chk("rst_x_out", x_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail_cnt", fail_cnt, 0);
    chk("rst_first_fail", first_fail, 0);
    chk("rst_rd_data", rd_data, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Clean len=3 run, then exp[1] and exp[2] corrupted with len=4.
    new_vectors(0);
    run_seq(3);
    chk("t1_fail_cnt", fail_cnt, 0);
    wr(1, stim_m[1], exp_m[1] ^ 13'h0001);
    wr(2, stim_m[2], exp_m[2] ^ 13'h1000);
    wr_end();
    run_seq(4);
    chk("t2_fail_cnt", fail_cnt, 2);
    chk("t2_first_fail", first_fail, 1);
    chk("t2_pass", pass, 0);

    // Empty run.
    run_seq(0);
    chk("t3_fail_cnt", fail_cnt, 0);

    // Abort at the second RUN cycle with a mismatch already counted at index 0.
    wr(0, stim_m[0], exp_m[0] ^ 13'h0040);
    wr_end();
    @(negedge clk);
    cfg_len = 6'd4; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_dut_rst", dut_rst, 1);
    chk("abort_done", done, 0);
    chk("abort_busy", busy, 0);
    chk("abort_fail_kept", fail_cnt, 1);
    @(posedge clk); #1;
    chk("abort_idle_busy", busy, 0);
    run_seq(4);
    chk("t4_first_fail", first_fail, 0);

    // Reset mid-run returns everything to reset values immediately.
    @(negedge clk);
    cfg_len = 6'd6; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_dut_rst", dut_rst, 1);
    chk("mid_rst_x_out", x_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_fail_cnt", fail_cnt, 0);
    chk("mid_rst_first_fail", first_fail, 0);
    @(negedge clk) rst = 1'b0;

    // Writes and start while busy must be ignored; the rerun proves RAM intact.
    fork
      run_seq(8);
      begin
        repeat (4) @(negedge clk);
        cfg_we = 1'b1; cfg_addr = '0; cfg_stim = ~stim_m[0]; cfg_exp = ~exp_m[0];
        start = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0; start = 1'b0;
      end
    join
    run_seq(8);

    // Randomized runs, including lengths beyond DEPTH.
    for (int r = 0; r < 5; r++) begin
      new_vectors(20);
      run_seq($urandom_range(40, 1));
    end
    run_seq(40);

`ifdef SEQ_CAPTURE_EN
    run_seq(5);
    for (int a = 0; a < 5; a++) begin
      @(negedge clk);
      rd_addr = AW'(a);
      #1;
      if (a > 0) chk("cap_latency", rd_data, cap_m[a-1]);
      @(posedge clk); #1;
      chk("cap_rd", rd_data, cap_m[a]);
    end
`else
    for (int a = 0; a < 5; a++) begin
      @(negedge clk);
      rd_addr = AW'(a);
      @(posedge clk); #1;
      chk("rd_data_zero", rd_data, 0);
    end
`endif

    repeat (3) @(negedge clk);
    chk("sb_drain", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end
endmodule
